// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift engine: opcodes, FSM states and
// the shift-amount width helper.
package shift_pkg;

  typedef enum logic [2:0] {
    SH_NOP  = 3'd0,
    SH_LOAD = 3'd1,
    SH_LSL  = 3'd2,
    SH_LSR  = 3'd3,
    SH_ASR  = 3'd4,
    SH_ROL  = 3'd5,
    SH_ROR  = 3'd6,
    SH_RSVD = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int sh_amt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP positions, built as a
// binary-weighted mux tree; also reports the last bit shifted/rotated out.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]        d,
  input  logic [2:0]              op,
  input  logic [$clog2(STEP):0]   k,
  output logic [WIDTH-1:0]        q,
  output logic                    out_bit
);

  localparam int KW = $clog2(STEP) + 1;
  localparam int AW = sh_amt_w(WIDTH);

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic [2:0]       o,
                                                input int               amt);
    case (o)
      SH_LSL:  return v << amt;
      SH_LSR:  return v >> amt;
      SH_ASR:  return $signed(v) >>> amt;
      SH_ROL:  return (v << amt) | (v >> (WIDTH - amt));
      SH_ROR:  return (v >> amt) | (v << (WIDTH - amt));
      default: return v;
    endcase
  endfunction

  logic [KW:0][WIDTH-1:0] stage;

  assign stage[0] = d;

  // mux tree: stage g conditionally moves the word by 2**g positions
  for (genvar g = 0; g < KW; g++) begin : g_stage
    assign stage[g+1] = k[g] ? shift_by(stage[g], op, 1 << g) : stage[g];
  end

  assign q = stage[KW];

  logic [AW-1:0] lsl_idx;
  logic [AW-1:0] rsh_idx;

  assign lsl_idx = AW'(WIDTH - int'(k));
  assign rsh_idx = AW'(int'(k) - 1);

  always_comb begin
    out_bit = 1'b0;
    if (k != '0) begin
      case (op)
        SH_LSL:         out_bit = d[lsl_idx];
        SH_LSR, SH_ASR: out_bit = d[rsh_idx];
        SH_ROL:         out_bit = q[0];
        SH_ROR:         out_bit = q[WIDTH-1];
        default:        out_bit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate register with start/busy/done handshake.
// Optional carry output enabled by defining SHIFT_ENGINE_CARRY_EN.
module shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [sh_amt_w(WIDTH)-1:0]  shamt,
  input  logic [WIDTH-1:0]            d_in,
  output logic [WIDTH-1:0]            d_out,
  output logic                        busy,
  output logic                        done
`ifdef SHIFT_ENGINE_CARRY_EN
  ,
  output logic                        carry
`endif
);

  localparam int AW = sh_amt_w(WIDTH);
  localparam int KW = $clog2(STEP) + 1;

  state_t        state;
  logic [AW-1:0] rem;
  logic [2:0]    op_r;

  logic [2:0]       op_cur;
  logic [AW-1:0]    amt_cur;
  logic [KW-1:0]    k;
  logic [AW-1:0]    rem_next;
  logic             is_shift;
  logic             accept;
  logic             load_cmd;
  logic             step_en;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  // In IDLE the step is driven straight from the command inputs so the
  // first step lands on the accept edge; in RUN from the latched command.
  assign op_cur   = (state == RUN) ? op_r : op;
  assign amt_cur  = (state == RUN) ? rem  : shamt;
  assign k        = (amt_cur > AW'(STEP)) ? KW'(STEP) : KW'(amt_cur);
  assign rem_next = amt_cur - AW'(k);
  assign is_shift = (op_cur >= SH_LSL) && (op_cur <= SH_ROR);

  assign accept   = (state == IDLE) && start;
  assign load_cmd = accept && (op == SH_LOAD);
  assign step_en  = (state == RUN) || (accept && is_shift && (shamt != '0));

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .d       (d_out),
    .op      (op_cur),
    .k       (k),
    .q       (step_q),
    .out_bit (step_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      d_out <= '0;
      rem   <= '0;
      op_r  <= SH_NOP;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            if (load_cmd) begin
              d_out <= d_in;
            end else if (step_en) begin
              d_out <= step_q;
            end
            if (step_en && (rem_next != '0)) begin
              rem   <= rem_next;
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              rem  <= '0;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          d_out <= step_q;
          rem   <= rem_next;
          if (rem_next == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_ENGINE_CARRY_EN
  // LOAD clears the flag; commands that do not move the word leave it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry <= 1'b0;
    end else if (load_cmd) begin
      carry <= 1'b0;
    end else if (step_en) begin
      carry <= step_bit;
    end
  end
`else
  logic unused_step_bit;
  assign unused_step_bit = step_bit;
`endif

endmodule

// File: tb/tb_shift_engine.sv
// Directed, table-driven bench for shift_engine (WIDTH=32, STEP=4).
module tb_shift_engine;
  import shift_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        busy;
  logic        done;
`ifdef SHIFT_ENGINE_CARRY_EN
  logic        carry;
`endif

  int checks = 0;
  int errors = 0;

  shift_engine #(.WIDTH(32), .STEP(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .d_in    (d_in),
    .d_out   (d_out),
    .busy    (busy),
    .done    (done)
`ifdef SHIFT_ENGINE_CARRY_EN
    ,
    .carry   (carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pre;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] exp_d;
    logic        exp_c;
    int          n;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait (bounded) for done; returns edges from accept
  // to the observed done and the number of busy cycles seen on the way.
  task automatic do_op(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d,
                       output int edges, output int busy_cyc);
    start = 1'b1;
    op    = o;
    shamt = s;
    d_in  = d;
    tick();
    start = 1'b0;
    op    = 3'd0;
    shamt = 5'd0;
    d_in  = 32'h0;
    edges    = 1;
    busy_cyc = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      tick();
      edges++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int e, b, dcnt;

    //            pre           op       sh  exp_d         c  n
    vt[0]  = '{32'h80000001, SH_LSL,  1,  32'h00000002, 1, 1};
    vt[1]  = '{32'h80000001, SH_LOAD, 0,  32'h80000001, 0, 1};
    vt[2]  = '{32'h80000001, SH_ASR,  9,  32'hFFC00000, 0, 3};
    vt[3]  = '{32'h80000001, SH_ROL,  31, 32'hC0000000, 0, 8};
    vt[4]  = '{32'h0000FF00, SH_LSR,  8,  32'h000000FF, 0, 2};
    vt[5]  = '{32'h12345678, SH_ROR,  4,  32'h81234567, 1, 1};
    vt[6]  = '{32'hA5A5A5A5, SH_LSR,  0,  32'hA5A5A5A5, 0, 1};
    vt[7]  = '{32'h00000005, SH_NOP,  3,  32'h00000005, 0, 1};
    vt[8]  = '{32'h00000005, SH_RSVD, 3,  32'h00000005, 0, 1};
    vt[9]  = '{32'h40000000, SH_ASR,  31, 32'h00000000, 1, 8};
    vt[10] = '{32'hFFFFFFFF, SH_LSL,  5,  32'hFFFFFFE0, 1, 2};
    vt[11] = '{32'h0F0F0F0F, SH_ROL,  4,  32'hF0F0F0F0, 0, 1};
    vt[12] = '{32'h80000000, SH_LSR,  31, 32'h00000001, 0, 8};
    vt[13] = '{32'h80000000, SH_ASR,  3,  32'hF0000000, 0, 1};

    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    shamt   = 5'd0;
    d_in    = 32'h0;
    tick();
    tick();
    chk("reset_d_out", d_out, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
`ifdef SHIFT_ENGINE_CARRY_EN
    chk("reset_carry", {31'd0, carry}, 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      if (vt[i].op != SH_LOAD) do_op(SH_LOAD, 5'd0, vt[i].pre, e, b);
      do_op(vt[i].op, vt[i].shamt, vt[i].pre, e, b);
      chk($sformatf("vec%0d_d_out", i), d_out, vt[i].exp_d);
      chk($sformatf("vec%0d_latency", i), e, vt[i].n);
      chk($sformatf("vec%0d_busy_cycles", i), b, vt[i].n - 1);
`ifdef SHIFT_ENGINE_CARRY_EN
      chk($sformatf("vec%0d_carry", i), {31'd0, carry}, {31'd0, vt[i].exp_c});
`endif
      tick();
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Carry must survive commands that leave the word in place.
    do_op(SH_LOAD, 5'd0, 32'h80000001, e, b);
    do_op(SH_LSL, 5'd1, 32'h0, e, b);
    do_op(SH_NOP, 5'd0, 32'h0, e, b);
    do_op(SH_LSR, 5'd0, 32'h0, e, b);
    do_op(SH_RSVD, 5'd4, 32'h0, e, b);
    chk("hold_d_out", d_out, 32'h00000002);
`ifdef SHIFT_ENGINE_CARRY_EN
    chk("hold_carry", {31'd0, carry}, 32'd1);
`endif

    // start with LOAD while busy is ignored, and only one done appears.
    do_op(SH_LOAD, 5'd0, 32'h0000FF00, e, b);
    start = 1'b1; op = SH_LSR; shamt = 5'd8; d_in = 32'h0;
    tick();
    chk("ign_busy", {31'd0, busy}, 32'd1);
    op = SH_LOAD; d_in = 32'hDEADBEEF; shamt = 5'd0;
    tick();
    start = 1'b0; op = 3'd0; d_in = 32'h0;
    dcnt = done ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk("ign_d_out", d_out, 32'h000000FF);
    chk("ign_done_count", dcnt, 1);

    // Back-to-back: start held across done, no idle cycle in between.
    do_op(SH_LOAD, 5'd0, 32'h0F0F0F0F, e, b);
    start = 1'b1; op = SH_LSL; shamt = 5'd4;
    tick();
    op = SH_LSR;
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    chk("b2b_first_d", d_out, 32'hF0F0F0F0);
    tick();
    start = 1'b0; op = 3'd0; shamt = 5'd0;
    chk("b2b_second_done", {31'd0, done}, 32'd1);
    chk("b2b_second_d", d_out, 32'h0F0F0F0F);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a multi-cycle rotate.
    do_op(SH_LOAD, 5'd0, 32'h12345678, e, b);
    start = 1'b1; op = SH_ROR; shamt = 5'd20;
    tick();
    start = 1'b0; op = 3'd0; shamt = 5'd0;
    tick();
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_d_out", d_out, 32'h0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    tick();
    reset_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    chk("rst_no_done_after", dcnt, 0);
    do_op(SH_LOAD, 5'd0, 32'h5A5A5A5A, e, b);
    chk("rst_then_load", d_out, 32'h5A5A5A5A);
    chk("rst_then_load_lat", e, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
